// File: rtl/core_mem_arb_pkg.sv
// Shared definitions for the core memory arbiter: FSM encoding and parameter defaults.
package core_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

  // Wide enough for the largest allowed burst limit (15).
  localparam int BURST_W = 4;

endpackage

// File: rtl/core_rr_pick.sv
// Combinational rotate-priority picker: the first requester at or after 'start'
// (wrapping around) wins.
module core_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic             valid
);

  // Two passes: indices from start upward, then the wrapped indices below start.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i] && (i >= int'(start))) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i] && (i < int'(start))) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between N_REQ requesters,
// with bounded bursting for a requester that keeps asking.
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [N_REQ-1:0]              i_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   i_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_wdata,
  output logic [N_REQ-1:0]              o_ack,
  output logic [N_REQ-1:0]              o_rvalid,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic                          o_mem_en,
  output logic                          o_mem_we,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  output logic [DATA_WIDTH-1:0]         o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]         i_mem_rdata
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_t state, next_state;

  logic [IDX_W-1:0]      last_grant, last_grant_d, rr_start, win_idx;
  logic [BURST_W-1:0]    burst_cnt, burst_d;
  logic [N_REQ-1:0]      rr_grant, win_onehot, ack_d, rvalid_d;
  logic                  rr_valid, hold_burst, arbitrate, en_d, we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  assign rr_start = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;

  core_rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (i_req),
    .start (rr_start),
    .grant (rr_grant),
    .valid (rr_valid)
  );

  // A zero burst count means no burst is in progress (after reset or idle),
  // so the previous grantee gets no preference over round-robin order.
  assign arbitrate  = (state != ISSUE) && rr_valid;
  assign hold_burst = i_req[last_grant] && (burst_cnt != '0) &&
                      (burst_cnt < BURST_W'(MAX_BURST));

  always_comb begin
    win_onehot = hold_burst ? (ONE_HOT0 << last_grant) : rr_grant;
    win_idx    = last_grant;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_onehot[i]) win_idx = IDX_W'(i);
    end
  end

  always_comb begin
    next_state = IDLE;
    unique case (state)
      IDLE:    next_state = arbitrate ? ISSUE : IDLE;
      ISSUE:   next_state = RESP;
      RESP:    next_state = arbitrate ? ISSUE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; the current o_ack/o_mem_we
  // describe the access being issued, which decides the response pulse.
  always_comb begin
    ack_d        = '0;
    rvalid_d     = '0;
    en_d         = 1'b0;
    we_d         = 1'b0;
    addr_d       = '0;
    wdata_d      = '0;
    last_grant_d = last_grant;
    burst_d      = burst_cnt;
    if (state == ISSUE) begin
      rvalid_d = o_mem_we ? '0 : o_ack;
    end else if (arbitrate) begin
      ack_d        = win_onehot;
      en_d         = 1'b1;
      we_d         = i_we[win_idx];
      addr_d       = i_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_d      = i_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
      last_grant_d = win_idx;
      burst_d      = hold_burst ? burst_cnt + 1'b1 : BURST_W'(1);
    end else begin
      burst_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      o_ack       <= '0;
      o_rvalid    <= '0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      last_grant  <= LAST_IDX;
      burst_cnt   <= '0;
    end else begin
      state       <= next_state;
      o_ack       <= ack_d;
      o_rvalid    <= rvalid_d;
      o_mem_en    <= en_d;
      o_mem_we    <= we_d;
      o_mem_addr  <= addr_d;
      o_mem_wdata <= wdata_d;
      last_grant  <= last_grant_d;
      burst_cnt   <= burst_d;
    end
  end

  assign o_rdata = (|o_rvalid) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: table of single accesses plus
// hand-written burst, round-robin and reset sequences, checked via a scoreboard.
module tb_core_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct {
    int          idx;
    bit          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    ack, rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  logic [N-1:0]    rr_ack, rr_rvalid;
  logic [DW-1:0]   rr_rdata;
  logic            rr_mem_en, rr_mem_we;
  logic [AW-1:0]   rr_mem_addr;
  logic [DW-1:0]   rr_mem_wdata;

  always #5 clk = ~clk;

  core_mem_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_ack(ack), .o_rvalid(rvalid), .o_rdata(rdata), .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  core_mem_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(1)
  ) dut_rr (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_ack(rr_ack), .o_rvalid(rr_rvalid), .o_rdata(rr_rdata), .o_mem_en(rr_mem_en),
    .o_mem_we(rr_mem_we), .o_mem_addr(rr_mem_addr), .o_mem_wdata(rr_mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // Memory model with one-cycle read latency, served by the main arbiter only.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      mem_rdata     <= 8'hEE;
      mem[8'h12]    <= 8'hA5;
      mem[8'hFE]    <= 8'h5A;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;
  int ack_count = 0;
  int ack_times[$];
  txn_t exp_q[$];

  bit            rd_pending = 1'b0;
  logic [N-1:0]  rd_onehot;
  logic [DW-1:0] rd_data;
  logic [N-1:0]  exp_rv;
  logic [DW-1:0] exp_rd;
  txn_t          mon_t;

  bit            rr_checking = 1'b0;
  logic [N-1:0]  rr_q[$];
  int            rr_times[$];
  logic [AW-1:0] rr_addrs[$];
  logic [DW-1:0] rr_wdatas[$];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    n_checks++;
    if (actual !== required)
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, required, cycle);
    else
      n_pass++;
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard monitor for the main arbiter.
  always @(negedge clk) begin
    if (rst) begin
      rd_pending = 1'b0;
    end else begin
      exp_rv     = rd_pending ? rd_onehot : '0;
      exp_rd     = rd_pending ? rd_data : '0;
      rd_pending = 1'b0;
      check_output("rvalid", rvalid, exp_rv);
      check_output("rdata", rdata, exp_rd);
      if (ack != '0) begin
        ack_count++;
        ack_times.push_back(cycle);
        if (exp_q.size() == 0) begin
          check_output("unexpected_ack", ack, 0);
        end else begin
          mon_t = exp_q.pop_front();
          check_output("ack_grant", ack, 32'(1) << mon_t.idx);
          check_output("mem_en", mem_en, 1);
          check_output("mem_we", mem_we, mon_t.we);
          check_output("mem_addr", mem_addr, mon_t.addr);
          if (mon_t.we) begin
            check_output("mem_wdata", mem_wdata, mon_t.wdata);
          end else begin
            rd_pending = 1'b1;
            rd_onehot  = N'(1) << mon_t.idx;
            rd_data    = mon_t.rdata;
          end
        end
      end else begin
        check_output("idle_mem_en", mem_en, 0);
        check_output("idle_mem_we", mem_we, 0);
      end
    end
  end

  // Recorder for the non-bursting instance.
  always @(negedge clk) begin
    if (rr_checking && !rst) begin
      check_output("rr_rvalid", rr_rvalid, 0);
      check_output("rr_rdata", rr_rdata, 0);
      if (rr_ack != '0) begin
        rr_q.push_back(rr_ack);
        rr_times.push_back(cycle);
        rr_addrs.push_back(rr_mem_addr);
        rr_wdatas.push_back(rr_mem_wdata);
        check_output("rr_mem_en", rr_mem_en, 1);
        check_output("rr_mem_we", rr_mem_we, 1);
      end
    end
  end

  task automatic wait_acks(input int target, input int budget, input string name);
    int n = 0;
    while (ack_count < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_output(name, ack_count, target);
  endtask

  task automatic apply_stimulus(input txn_t v);
    we[v.idx]              = v.we;
    addr[v.idx*AW +: AW]   = v.addr;
    wdata[v.idx*DW +: DW]  = v.wdata;
    exp_q.push_back(v);
    req[v.idx] = 1'b1;
    wait_acks(ack_count + 1, 20, "vec_ack");
    req[v.idx] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_spacing(input int first, input int count, input string name);
    for (int j = 1; j < count; j++) begin
      if (ack_times.size() > first + j)
        check_output(name, ack_times[first+j] - ack_times[first+j-1], 2);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txn_t vecs[8];
    int   base, t0, n;
    int   rr_order[5];

    vecs[0] = '{0, 1'b0, 8'h12, 8'h00, 8'hA5};
    vecs[1] = '{1, 1'b1, 8'h40, 8'h3C, 8'h00};
    vecs[2] = '{3, 1'b0, 8'h40, 8'h00, 8'h3C};
    vecs[3] = '{2, 1'b1, 8'h7F, 8'h81, 8'h00};
    vecs[4] = '{2, 1'b0, 8'h7F, 8'h00, 8'h81};
    vecs[5] = '{0, 1'b1, 8'h00, 8'hFF, 8'h00};
    vecs[6] = '{1, 1'b0, 8'h00, 8'h00, 8'hFF};
    vecs[7] = '{3, 1'b0, 8'hFE, 8'h00, 8'h5A};
    rr_order = '{0, 1, 2, 3, 0};

    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_ack", ack, 0);
    check_output("rst_rvalid", rvalid, 0);
    check_output("rst_mem_en", mem_en, 0);
    check_output("rst_mem_we", mem_we, 0);
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_mem_wdata", mem_wdata, 0);
    check_output("rst_rdata", rdata, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("post_rst_idle", ack_count, 0);

    $display("[TB] table of single accesses");
    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

    $display("[TB] round-robin, all four requesting");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rr_q.delete(); rr_times.delete(); rr_addrs.delete(); rr_wdatas.delete();
    rr_checking = 1'b1;
    base = ack_count;
    t0   = ack_times.size();
    for (int k = 0; k < N; k++) begin
      we[k]           = 1'b1;
      addr[k*AW +: AW] = AW'(8'h80 + k);
      wdata[k*DW +: DW] = DW'(8'h10 + k);
    end
    for (int j = 0; j < 5; j++)
      exp_q.push_back('{(j < 4) ? 0 : 1, 1'b1, (j < 4) ? 8'h80 : 8'h81,
                        (j < 4) ? 8'h10 : 8'h11, 8'h00});
    req = '1;
    wait_acks(base + 5, 30, "rr_ack");
    req = '0;
    repeat (4) @(posedge clk);
    #1;
    rr_checking = 1'b0;
    check_output("rr_count", rr_q.size(), 5);
    for (int j = 0; j < 5; j++) begin
      if (rr_q.size() > j) begin
        check_output("rr_order", rr_q[j], 32'(1) << rr_order[j]);
        check_output("rr_addr", rr_addrs[j], 32'h80 + rr_order[j]);
        check_output("rr_wdata", rr_wdatas[j], 32'h10 + rr_order[j]);
        if (j > 0) check_output("rr_spacing", rr_times[j] - rr_times[j-1], 2);
      end
    end
    check_spacing(t0, 5, "burst4_spacing");

    $display("[TB] requester 2 alone, six back-to-back writes");
    base = ack_count;
    t0   = ack_times.size();
    for (int j = 0; j < 6; j++)
      exp_q.push_back('{2, 1'b1, AW'(8'h20 + j), DW'(8'h60 + j), 8'h00});
    we[2] = 1'b1;
    addr[2*AW +: AW]  = 8'h20;
    wdata[2*DW +: DW] = 8'h60;
    req[2] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      wait_acks(base + j + 1, 10, "b2b_ack");
      if (j < 5) begin
        addr[2*AW +: AW]  = AW'(8'h21 + j);
        wdata[2*DW +: DW] = DW'(8'h61 + j);
      end else begin
        req[2] = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check_spacing(t0, 6, "b2b_spacing");

    $display("[TB] burst limit with a late competitor");
    base = ack_count;
    we[1] = 1'b1; addr[1*AW +: AW] = 8'h30; wdata[1*DW +: DW] = 8'h70;
    we[3] = 1'b1; addr[3*AW +: AW] = 8'h38; wdata[3*DW +: DW] = 8'h77;
    for (int j = 0; j < 6; j++) begin
      if (j == 4) exp_q.push_back('{3, 1'b1, 8'h38, 8'h77, 8'h00});
      else        exp_q.push_back('{1, 1'b1, 8'h30, 8'h70, 8'h00});
    end
    req[1] = 1'b1;
    wait_acks(base + 2, 10, "burst_ack2");
    req[3] = 1'b1;
    wait_acks(base + 5, 20, "burst_ack5");
    req[3] = 1'b0;
    wait_acks(base + 6, 10, "burst_ack6");
    req[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset during an issued read");
    base = ack_count;
    we[3] = 1'b0; addr[3*AW +: AW] = 8'h12;
    exp_q.push_back('{3, 1'b0, 8'h12, 8'h00, 8'hA5});
    req[3] = 1'b1;
    n = 0;
    while (ack == '0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("rst_pre_ack", ack, 4'b1000);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_output("rst_async_ack", ack, 0);
    check_output("rst_async_en", mem_en, 0);
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_output("rst_no_ack", ack_count, base + 1);

    we[1] = 1'b1; addr[1*AW +: AW] = 8'h91; wdata[1*DW +: DW] = 8'h11;
    we[3] = 1'b1; addr[3*AW +: AW] = 8'h90; wdata[3*DW +: DW] = 8'h33;
    exp_q.push_back('{1, 1'b1, 8'h91, 8'h11, 8'h00});
    exp_q.push_back('{3, 1'b1, 8'h90, 8'h33, 8'h00});
    req[1] = 1'b1;
    req[3] = 1'b1;
    wait_acks(base + 2, 10, "post_rst_first");
    req[1] = 1'b0;
    wait_acks(base + 3, 10, "post_rst_second");
    req[3] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter ADDR_WIDTH, default 8, shared-memory address width.
REQ-003 Parameter DATA_WIDTH, default 8, shared-memory data width.
REQ-004 Parameter MAX_BURST, default 4, maximum back-to-back grants to one requester while others wait (1..15).
REQ-005 One clock, i_clk; reset i_rst is asynchronous, active-high.
REQ-006 i_clk  input  1  processor clock, all state on rising edge.
REQ-007 i_rst  input  1  asynchronous active-high reset.
REQ-008 i_req  input  N_REQ  per-requester access request, level.
REQ-009 i_we  input  N_REQ  per-requester write enable, qualifies i_req.
REQ-010 i_addr  input  N_REQ*ADDR_WIDTH  packed requester addresses, requester k at slice k.
REQ-011 i_wdata  input  N_REQ*DATA_WIDTH  packed requester write data.
REQ-012 o_ack  output  N_REQ  one-hot, access accepted this cycle.
REQ-013 o_rvalid  output  N_REQ  one-hot, read data valid this cycle.
REQ-014 o_rdata  output  DATA_WIDTH  read data, shared by all requesters.
REQ-015 o_mem_en, o_mem_we  output  1 each  memory strobe and write enable.
REQ-016 o_mem_addr, o_mem_wdata  output  ADDR_WIDTH, DATA_WIDTH  memory address and write data.
REQ-017 i_mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after o_mem_en.

Function
REQ-018 FSM states IDLE, ISSUE, RESP; IDLE and RESP both arbitrate.
REQ-019 In IDLE or RESP with any i_req high: select winner, next state ISSUE; else next state IDLE.
REQ-020 On entry to ISSUE: o_mem_en=1, o_ack[g]=1, o_mem_we/addr/wdata = winner's registered values, all for exactly one cycle.
REQ-021 ISSUE always goes to RESP; in RESP o_mem_en=0, o_rvalid[g]=1 only if access was a read, o_rdata = i_mem_rdata.
REQ-022 o_rdata = 0 whenever no o_rvalid bit is set.
REQ-023 Latency: request sampled at edge E0 -> o_ack in cycle after E0 -> o_rvalid in cycle after E1; max throughput one access per 2 cycles.
REQ-024 Requester holds i_we/i_addr/i_wdata stable until its o_ack; it may change them or drop i_req from the edge ending the ack cycle.
REQ-025 Access is committed at ISSUE entry; dropping i_req during ISSUE or RESP does not cancel it.
REQ-026 Round-robin: search starts at last_grant+1 modulo N_REQ; first requester with i_req high wins.
REQ-027 Burst: if last grantee still requests and burst_cnt < MAX_BURST, it wins again and burst_cnt increments.
REQ-028 At burst_cnt = MAX_BURST, normal round-robin applies; if no other requester is high, grantee wins and burst_cnt restarts at 1.
REQ-029 burst_cnt is set to 1 on any grant to a different requester, and cleared in IDLE.
REQ-030 Requests dropped before being granted are ignored without side effect.
REQ-031 o_ack and o_rvalid never have more than one bit set and are never set in the same cycle.

Reset
REQ-032 On i_rst: state IDLE; o_ack, o_rvalid, o_mem_en, o_mem_we = 0; o_mem_addr, o_mem_wdata, o_rdata = 0; burst_cnt = 0; last_grant = N_REQ-1 so requester 0 has first priority.
REQ-033 Reset asserted mid-access aborts it immediately; no ack or rvalid follows reset release without a fresh request.
REQ-034 First arbitration occurs on the first rising edge after i_rst deasserts.

Structure
REQ-035 Package core_mem_arb_pkg holds the FSM state encoding and parameter defaults.
REQ-036 Sub-module core_rr_pick: combinational rotate-priority picker (req vector, start index -> one-hot grant, valid).
REQ-037 All outputs are registered except o_rdata, which passes i_mem_rdata through in RESP only.

Verification
REQ-038 Single read: req[0]=1, addr 0x12, mem holds 0xA5 -> ack[0] one cycle after sampling, rvalid[0] with o_rdata=0xA5 next cycle.
REQ-039 All four requesting continuously, no bursting (MAX_BURST=1) -> grant order 0,1,2,3,0, ack every 2 cycles.
REQ-040 Requester 2 alone, 6 back-to-back writes, MAX_BURST=4 -> 6 acks at 2-cycle spacing, burst_cnt 1,2,3,4,1,2.
REQ-041 Requester 1 bursting, requester 3 raises req during its 2nd access, MAX_BURST=4 -> requester 1 gets 4 acks, then requester 3.
REQ-042 i_rst asserted in ISSUE cycle -> o_mem_en and o_ack drop asynchronously, no o_rvalid follows; first post-reset grant goes to lowest active index.
REQ-043 Write then read same address 0x40 data 0x3C from different requesters -> o_mem_we pulse, later rvalid with 0x3C; o_rvalid never set for writes.
